// File: rtl/hybrid_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : hybrid_branch_predictor
//  Purpose  : Fetch-side tournament predictor. A bimodal table, a gshare
//             table and a chooser table (all 2-bit counters) give the
//             direction. A direct-mapped BTB gives the taken target.
//             Prediction is combinational from fetch_pc and the table state.
//             The tables are trained by the resolved branch coming back
//             from EX.
//  Ports    : clk              core clock
//             rst              asynchronous, active-low reset
//             fetch_pc         PC fetched this cycle
//             fetch_valid      fetch_pc is a real fetch
//             prediction       predict taken
//             predicted_target BTB target when taken, else fetch_pc+4
//             pred_ghr         history used for this prediction
//             update_valid     resolved conditional branch this cycle
//             update_pc        PC of the resolved branch
//             update_taken     actual outcome
//             update_target    actual taken target
//             update_ghr       pred_ghr that travelled with the branch
//  Revision : 1.0  initial release
// ============================================================================
module hybrid_branch_predictor #(
   parameter int INDEX_BITS = 6,
   parameter int GHR_BITS   = 6,
   parameter int TAG_BITS   = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         fetch_pc,
   input  logic                fetch_valid,
   output logic                prediction,
   output logic [31:0]         predicted_target,
   output logic [GHR_BITS-1:0] pred_ghr,
   input  logic                update_valid,
   input  logic [31:0]         update_pc,
   input  logic                update_taken,
   input  logic [31:0]         update_target,
   input  logic [GHR_BITS-1:0] update_ghr
);

   localparam int c_entries = 1 << INDEX_BITS;
   localparam int c_tag_lo  = INDEX_BITS + 2;
   localparam int c_tag_hi  = INDEX_BITS + TAG_BITS + 1;

   // Table storage, all flops so reads are combinational.
   logic [1:0]          r_bim     [c_entries];
   logic [1:0]          r_gsh     [c_entries];
   logic [1:0]          r_cho     [c_entries];
   logic                r_btb_vld [c_entries];
   logic [TAG_BITS-1:0] r_btb_tag [c_entries];
   logic [31:0]         r_btb_tgt [c_entries];
   logic [GHR_BITS-1:0] r_ghr;

   // Saturating 2-bit counter step.
   function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic up);
      logic [1:0] res;
      res = ctr;
      if (up && ctr != 2'b11)
         res = ctr + 2'b01;
      else if (!up && ctr != 2'b00)
         res = ctr - 2'b01;
      return res;
   endfunction

   // ---------------------------------------------------------------- predict
   logic [INDEX_BITS-1:0] w_idx;
   logic [INDEX_BITS-1:0] w_gidx;
   logic [TAG_BITS-1:0]   w_tag;
   logic [1:0]            w_bi;
   logic [1:0]            w_gs;
   logic [1:0]            w_ch;
   logic [1:0]            w_sel;
   logic                  w_hit;
   logic [31:0]           w_seq_pc;

   assign w_idx    = fetch_pc[INDEX_BITS+1:2];
   assign w_gidx   = w_idx ^ INDEX_BITS'(r_ghr);
   assign w_tag    = fetch_pc[c_tag_hi:c_tag_lo];
   assign w_bi     = r_bim[w_idx];
   assign w_gs     = r_gsh[w_gidx];
   assign w_ch     = r_cho[w_idx];
   assign w_sel    = w_ch[1] ? w_gs : w_bi;
   assign w_hit    = r_btb_vld[w_idx] && (r_btb_tag[w_idx] == w_tag);
   assign w_seq_pc = fetch_pc + 32'd4;

   // A taken direction with a BTB miss falls back to sequential fetch,
   // since there is no target to redirect to.
   assign prediction       = fetch_valid & w_sel[1] & w_hit;
   assign predicted_target = prediction ? r_btb_tgt[w_idx] : w_seq_pc;
   assign pred_ghr         = r_ghr;

   // ----------------------------------------------------------------- update
   logic [INDEX_BITS-1:0] w_uidx;
   logic [INDEX_BITS-1:0] w_ugidx;
   logic [1:0]            w_u_bi;
   logic [1:0]            w_u_gs;
   logic [1:0]            w_u_ch;
   logic                  w_bi_ok;
   logic                  w_gs_ok;

   assign w_uidx  = update_pc[INDEX_BITS+1:2];
   assign w_ugidx = w_uidx ^ INDEX_BITS'(update_ghr);
   assign w_u_bi  = r_bim[w_uidx];
   assign w_u_gs  = r_gsh[w_ugidx];
   assign w_u_ch  = r_cho[w_uidx];
   // Chooser is judged on the counters as they were before this update.
   assign w_bi_ok = (w_u_bi[1] == update_taken);
   assign w_gs_ok = (w_u_gs[1] == update_taken);

   // Word-offset and above-tag PC bits play no part in indexing or tagging.
   logic w_unused_pc;
   assign w_unused_pc = &{1'b0, update_pc[1:0], update_pc[31:c_tag_hi+1]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < c_entries; i++) begin
            r_bim[i]     <= 2'b01;
            r_gsh[i]     <= 2'b01;
            r_cho[i]     <= 2'b01;
            r_btb_vld[i] <= 1'b0;
            r_btb_tag[i] <= '0;
            r_btb_tgt[i] <= '0;
         end
         r_ghr <= '0;
      end else if (update_valid) begin
         r_bim[w_uidx]  <= ctr_next(w_u_bi, update_taken);
         r_gsh[w_ugidx] <= ctr_next(w_u_gs, update_taken);
         if (w_bi_ok && !w_gs_ok)
            r_cho[w_uidx] <= ctr_next(w_u_ch, 1'b0);
         else if (w_gs_ok && !w_bi_ok)
            r_cho[w_uidx] <= ctr_next(w_u_ch, 1'b1);
         if (update_taken) begin
            r_btb_vld[w_uidx] <= 1'b1;
            r_btb_tag[w_uidx] <= update_pc[c_tag_hi:c_tag_lo];
            r_btb_tgt[w_uidx] <= update_target;
         end
         // History is non-speculative: shifted only at resolution.
         r_ghr <= {r_ghr[GHR_BITS-2:0], update_taken};
      end
   end

endmodule
`default_nettype wire

// File: doc/hybrid_branch_predictor.md
Name: hybrid_branch_predictor

Overview:
- Fetch-side predictor that drives the predict-taken select and predicted-target input of the PC mux, upstream of the IF/ID register.
- Each cycle it predicts the branch at fetch_pc using three tables: a bimodal table, a gshare table and a chooser table, all 2-bit counters.
- Taken predictions take their target from a direct-mapped BTB.
- The EX stage trains all tables with the resolved outcome. pred_ghr travels down the pipe with the instruction and returns as update_ghr.

Parameters:
- INDEX_BITS, 6, log2 of the entry count shared by all tables. Index = pc[INDEX_BITS+1:2].
- GHR_BITS, 6, width of the global history register. Must be <= INDEX_BITS.
- TAG_BITS, 8, BTB tag width. Tag = pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2].

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, asynchronous, active-low.
- fetch_pc  in  32  PC being fetched this cycle.
- fetch_valid  in  1  fetch_pc is a real fetch.
- prediction  out  1  predict taken.
- predicted_target  out  32  next PC: BTB target if prediction=1, else fetch_pc+4.
- pred_ghr  out  GHR_BITS  GHR value used for this prediction.
- update_valid  in  1  resolved conditional branch in EX this cycle.
- update_pc  in  32  PC of the resolved branch.
- update_taken  in  1  actual outcome.
- update_target  in  32  actual taken target.
- update_ghr  in  GHR_BITS  pred_ghr carried with that branch.

Behaviour:
Prediction path:
- Combinational from fetch_pc and the current table state. Zero-cycle latency.
- bi = B[idx]. gs = G[idx ^ zero-extended ghr]. ch = C[idx].
- Selected counter = gs if ch >= 2, else bi. dir = selected[1].
- BTB hit = valid[idx] and tag[idx] == fetch_pc tag.
- prediction = fetch_valid & dir & hit.
- predicted_target = btb_target[idx] when prediction=1, else fetch_pc+4, 32-bit wrap (0xFFFFFFFC -> 0x0).
- pred_ghr = ghr.

Update path (posedge clk with update_valid=1; nothing changes otherwise):
- Update index ui = update_pc index. Gshare update index = ui ^ update_ghr.
- B[ui] and G[ui ^ update_ghr]: saturating 2-bit counters. Increment if taken, saturating at 3. Decrement if not taken, saturating at 0.
- Chooser C[ui], judged on the pre-update counter values:
  - bimodal correct and gshare wrong -> decrement, saturating at 0.
  - gshare correct and bimodal wrong -> increment, saturating at 3.
  - otherwise unchanged.
- BTB, when update_taken=1: write valid=1, tag and update_target at ui. Overwrites any different tag at that index. Not-taken updates leave the BTB untouched.
- ghr <= {ghr[GHR_BITS-2:0], update_taken}. History is non-speculative and updates at resolution only.

Reset (rst=0, asynchronous, effective immediately, including mid-operation):
- All B, G and C counters = 2'b01.
- ghr = 0. All BTB valid bits = 0.
- Outputs immediately become prediction=0, predicted_target=fetch_pc+4, pred_ghr=0.
- An update_valid asserted during reset is ignored.

Boundary conditions:
- Fetch and update in the same cycle at the same index: the prediction uses the pre-edge values. The new values are visible on the cycle after the edge.
- fetch_valid=0: prediction=0. Tables are unaffected.
- Direction is taken but the BTB misses: prediction=0, target=fetch_pc+4.
- Storage is flops; no reads are registered.

Test Plan:
1. Reset: hold rst=0, then release. fetch_pc=0x100, fetch_valid=1 -> prediction=0, predicted_target=0x104, pred_ghr=0.
2. Single train: update pc=0x40, taken=1, target=0x80, ghr=0. Next cycle fetch 0x40 -> bimodal 01->10, prediction=1, target=0x80, pred_ghr=6'b000001.
3. Saturation: 5 taken updates at pc=0x40, then 1 not-taken -> B[16]=2'b10 and fetch 0x40 still gives prediction=1. Three taken updates from ghr=0 -> pred_ghr=6'b000111.
4. Tag alias: after scenario 2, fetch 0x140 (same index 16, different tag) -> prediction=0, target=0x144.
5. Chooser: preload B[ui]=01 and G[ui^ghr]=10, then update taken=1 -> C[ui] 01->10. The next fetch selects gshare.
6. Collision and reset: same-cycle fetch/update at 0x40 -> old prediction that cycle, new value the next cycle. Assert rst mid-stream -> prediction drops to 0 without waiting for a clock edge.
